// File: rtl/alarm_beeper.sv
// Alarm cadence controller: gates the tone generator's enable with a beep/burst
// pattern, with snooze, dismiss and auto-timeout after a fixed number of bursts.
module alarm_beeper #(
    parameter int TICK_CYCLES     = 100000,
    parameter int ON_MS           = 200,
    parameter int OFF_MS          = 150,
    parameter int BEEPS_PER_BURST = 4,
    parameter int GAP_MS          = 1000,
    parameter int MAX_BURSTS      = 60,
    parameter int SNOOZE_MS       = 300000,
    parameter int MAX_SNOOZES     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic alarm_trigger,
    input  logic snooze_btn,
    input  logic dismiss_btn,
    output logic buzzer_on,
    output logic alarm_active,
    output logic snoozing,
    output logic timed_out
);

    localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int BEEP_W  = (BEEPS_PER_BURST < 1) ? 1 : $clog2(BEEPS_PER_BURST + 1);
    localparam int BURST_W = (MAX_BURSTS < 1) ? 1 : $clog2(MAX_BURSTS + 1);
    localparam int SNZ_W   = (MAX_SNOOZES < 1) ? 1 : $clog2(MAX_SNOOZES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [BEEP_W-1:0]  BEEP_MAX   = BEEP_W'(BEEPS_PER_BURST);
    localparam logic [BURST_W-1:0] BURST_MAX  = BURST_W'(MAX_BURSTS);
    localparam logic [SNZ_W-1:0]   SNZ_MAX    = SNZ_W'(MAX_SNOOZES);

    localparam logic [31:0] ON_LAST     = 32'(ON_MS - 1);
    localparam logic [31:0] OFF_LAST    = 32'(OFF_MS - 1);
    localparam logic [31:0] GAP_LAST    = 32'(GAP_MS - 1);
    localparam logic [31:0] SNOOZE_LAST = 32'(SNOOZE_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        BEEP_ON,
        BEEP_OFF,
        GAP,
        SNOOZE
    } state_t;

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [31:0]          phase_q, phase_d;
    logic [BEEP_W-1:0]    beep_q, beep_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [SNZ_W-1:0]     snz_q, snz_d;
    logic                 buzzer_q, active_q, snoozing_q, timed_out_q;
    logic                 timed_out_d;

    logic                 tick;
    logic                 expire;
    logic [31:0]          phase_last;
    logic [BEEP_W-1:0]    beep_inc;
    logic [BURST_W-1:0]   burst_inc;

    assign tick      = (presc_q == PRESC_LAST);
    assign beep_inc  = beep_q + BEEP_W'(1);
    assign burst_inc = burst_q + BURST_W'(1);

    always_comb begin
        phase_last = ON_LAST;
        case (state_q)
            BEEP_OFF: phase_last = OFF_LAST;
            GAP:      phase_last = GAP_LAST;
            SNOOZE:   phase_last = SNOOZE_LAST;
            default:  phase_last = ON_LAST;
        endcase
    end

    assign expire = tick && (phase_q == phase_last);

    always_comb begin
        state_d     = state_q;
        beep_d      = beep_q;
        burst_d     = burst_q;
        snz_d       = snz_q;
        timed_out_d = 1'b0;
        presc_d     = '0;
        phase_d     = '0;

        // Phase timing only runs while the alarm is active.
        if (state_q != IDLE) begin
            if (tick) begin
                presc_d = '0;
                phase_d = phase_q + 32'd1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
                phase_d = phase_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (alarm_trigger) begin
                    state_d = BEEP_ON;
                    beep_d  = '0;
                    burst_d = '0;
                    snz_d   = '0;
                end
            end
            default: begin
                if (dismiss_btn) begin
                    state_d = IDLE;
                end else if (snooze_btn && (state_q != SNOOZE) && (snz_q < SNZ_MAX)) begin
                    state_d = SNOOZE;
                    snz_d   = snz_q + SNZ_W'(1);
                end else if (expire) begin
                    case (state_q)
                        BEEP_ON: begin
                            if (beep_inc < BEEP_MAX) begin
                                beep_d  = beep_inc;
                                state_d = BEEP_OFF;
                            end else begin
                                state_d = GAP;
                            end
                        end
                        BEEP_OFF: state_d = BEEP_ON;
                        GAP: begin
                            beep_d  = '0;
                            burst_d = burst_inc;
                            if (burst_inc == BURST_MAX) begin
                                state_d     = IDLE;
                                timed_out_d = 1'b1;
                            end else begin
                                state_d = BEEP_ON;
                            end
                        end
                        SNOOZE: begin
                            // Returning from snooze restarts the timeout budget.
                            beep_d  = '0;
                            burst_d = '0;
                            state_d = BEEP_ON;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            phase_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            phase_q     <= '0;
            beep_q      <= '0;
            burst_q     <= '0;
            snz_q       <= '0;
            buzzer_q    <= 1'b0;
            active_q    <= 1'b0;
            snoozing_q  <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            beep_q      <= beep_d;
            burst_q     <= burst_d;
            snz_q       <= snz_d;
            buzzer_q    <= (state_d == BEEP_ON);
            active_q    <= (state_d != IDLE);
            snoozing_q  <= (state_d == SNOOZE);
            timed_out_q <= timed_out_d;
        end
    end

    assign buzzer_on    = buzzer_q;
    assign alarm_active = active_q;
    assign snoozing     = snoozing_q;
    assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_alarm_beeper.sv
// Scoreboard bench for alarm_beeper: per-cycle expected outputs are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_alarm_beeper;

    logic clk = 1'b0;
    logic rst;
    logic alarm_trigger;
    logic snooze_btn;
    logic dismiss_btn;
    logic buzzer_on;
    logic alarm_active;
    logic snoozing;
    logic timed_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] v;
        int         sc;
        int         k;
    } exp_t;

    exp_t q[$];

    alarm_beeper #(
        .TICK_CYCLES    (4),
        .ON_MS          (3),
        .OFF_MS         (2),
        .BEEPS_PER_BURST(2),
        .GAP_MS         (5),
        .MAX_BURSTS     (2),
        .SNOOZE_MS      (10),
        .MAX_SNOOZES    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alarm_trigger(alarm_trigger),
        .snooze_btn   (snooze_btn),
        .dismiss_btn  (dismiss_btn),
        .buzzer_on    (buzzer_on),
        .alarm_active (alarm_active),
        .snoozing     (snoozing),
        .timed_out    (timed_out)
    );

    always #5 clk = ~clk;

    function automatic logic in_rng(int k, int lo, int hi);
        return (k >= lo) && (k <= hi);
    endfunction

    // Hand-derived expected outputs {buzzer_on, alarm_active, snoozing, timed_out}
    // for the value visible between edge k-1 and edge k.
    function automatic logic [3:0] expv(int sc, int k);
        logic b, a, s, t;
        b = 1'b0; a = 1'b0; s = 1'b0; t = 1'b0;
        case (sc)
            1: begin
                b = (k >= 4);
                a = b;
            end
            2, 6: begin
                b = in_rng(k, 1, 12) || in_rng(k, 21, 32) || in_rng(k, 53, 64) || in_rng(k, 73, 84);
                a = in_rng(k, 1, 104);
                t = (k == 105);
            end
            3: begin
                b = in_rng(k, 1, 5) || in_rng(k, 46, 57) || in_rng(k, 66, 70);
                s = in_rng(k, 6, 45);
                a = in_rng(k, 1, 70);
            end
            4: begin
                b = in_rng(k, 1, 12) || in_rng(k, 21, 25) || in_rng(k, 31, 42);
                a = in_rng(k, 1, 25) || in_rng(k, 31, 45);
            end
            5: begin
                b = in_rng(k, 1, 10);
                a = b;
            end
            7: begin
                b = in_rng(k, 1, 12) || in_rng(k, 21, 32) || in_rng(k, 53, 64) || in_rng(k, 73, 84);
                a = in_rng(k, 1, 104);
            end
            default: ;
        endcase
        return {b, a, s, t};
    endfunction

    // Stimulus sampled at edge k: {rst, alarm_trigger, snooze_btn, dismiss_btn}.
    function automatic logic [3:0] stimv(int sc, int k);
        logic r, tr, sn, di;
        r = 1'b0; tr = 1'b0; sn = 1'b0; di = 1'b0;
        case (sc)
            1: begin
                r  = (k <= 2);
                tr = (k <= 3);
            end
            2: tr = (k == 0);
            3: begin
                tr = (k == 0);
                sn = (k == 5) || (k == 50);
            end
            4: begin
                tr = (k == 0) || (k == 30);
                di = (k == 25);
            end
            5: begin
                tr = (k == 0);
                sn = (k == 10);
                di = (k == 10);
            end
            6: tr = (k == 0) || (k == 15) || (k == 40);
            7: begin
                tr = (k == 0);
                di = (k == 104);
            end
            default: ;
        endcase
        return {r, tr, sn, di};
    endfunction

    function automatic int last_cycle(int sc);
        case (sc)
            1:       return 6;
            3:       return 70;
            4:       return 45;
            5:       return 20;
            default: return 110;
        endcase
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [3:0] got;
            e   = q.pop_front();
            got = {buzzer_on, alarm_active, snoozing, timed_out};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL scen%0d cyc%0d outputs(buz,act,snz,to) got=%b want=%b",
                         e.sc, e.k, got, e.v);
            end
        end
    end

    task automatic run_scenario(int sc);
        logic [3:0] st;
        exp_t e;
        rst = 1'b1; alarm_trigger = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k <= last_cycle(sc); k++) begin
            st = stimv(sc, k);
            rst           = st[3];
            alarm_trigger = st[2];
            snooze_btn    = st[1];
            dismiss_btn   = st[0];
            e.v  = expv(sc, k);
            e.sc = sc;
            e.k  = k;
            q.push_back(e);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; alarm_trigger = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; alarm_trigger = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
        repeat (3) @(posedge clk);
        for (int sc = 1; sc <= 7; sc++) begin
            run_scenario(sc);
        end
        repeat (2) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_beeper.md
Name: alarm_beeper

Overview:
- Alarm cadence controller that sits directly upstream of the tone generator. It drives that block's `buzzer_on` enable with a timed beep/burst pattern.
- An alarm trigger starts the pattern. Snooze and dismiss buttons pause or stop it. The alarm times out on its own after a fixed number of bursts.
- The tone generator's tone frequency and amplifier control are unchanged. This block only decides when the tone sounds.

Parameters:
- TICK_CYCLES, 100000, clock cycles per 1 ms tick (100 MHz). Overridden to small values in simulation.
- ON_MS, 200, length of one beep, in ticks.
- OFF_MS, 150, silence between beeps within a burst, in ticks.
- BEEPS_PER_BURST, 4, beeps per burst (>=1).
- GAP_MS, 1000, silence after the last beep of a burst, in ticks.
- MAX_BURSTS, 60, bursts before auto-timeout (>=1).
- SNOOZE_MS, 300000, snooze duration, in ticks.
- MAX_SNOOZES, 3, snoozes accepted per alarm. 0 disables snooze.

Ports:
- clk, input, 1, system clock, 100 MHz.
- rst, input, 1, synchronous active-high reset.
- alarm_trigger, input, 1, level or pulse; starts the alarm when sampled high in IDLE.
- snooze_btn, input, 1, debounced single-cycle pulse.
- dismiss_btn, input, 1, debounced single-cycle pulse.
- buzzer_on, output, 1, tone enable to the tone generator.
- alarm_active, output, 1, high in any state except IDLE.
- snoozing, output, 1, high in SNOOZE.
- timed_out, output, 1, one-cycle pulse on auto-timeout.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- While rst is high: state goes to IDLE; all counters clear; all outputs are 0. Reset mid-pattern aborts the pattern immediately, on the next edge.
- All outputs are registered or decoded from registered state:
  - buzzer_on = (state == BEEP_ON)
  - alarm_active = (state != IDLE)
  - snoozing = (state == SNOOZE)
- States: IDLE, BEEP_ON, BEEP_OFF, GAP, SNOOZE.
- Timing:
  - A prescaler counts TICK_CYCLES cycles per tick.
  - A 32-bit phase timer counts ticks.
  - Both clear on every state transition. A phase of X ticks therefore lasts exactly X*TICK_CYCLES cycles.
- IDLE -> BEEP_ON when alarm_trigger is sampled high. buzzer_on rises one cycle later. This entry clears beep_cnt, burst_cnt and snooze_cnt.
- BEEP_ON expiry:
  - If beep_cnt+1 < BEEPS_PER_BURST: increment beep_cnt, go to BEEP_OFF.
  - Otherwise: go to GAP.
- BEEP_OFF expiry -> BEEP_ON.
- GAP expiry:
  - Clear beep_cnt and increment burst_cnt.
  - If the new burst_cnt == MAX_BURSTS: go to IDLE and assert timed_out in the first IDLE cycle.
  - Otherwise: go to BEEP_ON.
- snooze_btn in BEEP_ON, BEEP_OFF or GAP:
  - Accepted only if snooze_cnt < MAX_SNOOZES; otherwise ignored.
  - On accept: go to SNOOZE, increment snooze_cnt.
- SNOOZE expiry -> BEEP_ON. Clears beep_cnt and burst_cnt; the timeout budget restarts.
- snooze_btn in SNOOZE is ignored.
- dismiss_btn in any non-IDLE state -> IDLE. No timed_out pulse.
- Priority when events coincide in one cycle:
  - dismiss_btn, then snooze_btn, then phase expiry.
  - A timeout at GAP expiry coincident with dismiss is treated as a dismiss (no timed_out).
- alarm_trigger is ignored outside IDLE. Retriggering never restarts or extends a running alarm.
- A trigger held high across a dismiss or timeout restarts the alarm one cycle after IDLE is entered. The IDLE cycle itself always shows buzzer_on = 0.
- Counter widths are sized with $clog2 from the parameters. No counter may wrap under legal parameters.

Test Plan:
All scenarios use TICK_CYCLES=4, ON_MS=3, OFF_MS=2, BEEPS_PER_BURST=2, GAP_MS=5, MAX_BURSTS=2, SNOOZE_MS=10, MAX_SNOOZES=1. Cycle 0 is the edge at which the stimulus is sampled.

1. Reset.
   - Stimulus: rst high for 3 cycles with alarm_trigger high.
   - Required: all outputs 0 throughout. After rst falls, buzzer_on rises on the next cycle.
2. Full cadence and timeout.
   - Stimulus: trigger pulse at cycle 0.
   - Required: buzzer_on high on cycles 1-12, 21-32, 53-64 and 73-84; low otherwise.
   - Required: timed_out high only on cycle 105; alarm_active low from cycle 105.
3. Snooze.
   - Stimulus: trigger at 0, snooze_btn at 5.
   - Required: buzzer_on low from 6; snoozing high 6-45; buzzer_on high 46-57.
   - Required: a second snooze_btn at 50 is ignored (buzzer_on stays high).
4. Dismiss.
   - Stimulus: trigger at 0, dismiss_btn at 25.
   - Required: all outputs 0 from 26; timed_out never asserted.
   - Required: a trigger at 30 restarts the alarm, buzzer_on high 31-42.
5. Simultaneous events.
   - Stimulus: snooze_btn and dismiss_btn together at cycle 10.
   - Required: IDLE at 11, snoozing never high.
   - Stimulus: dismiss_btn at cycle 104 (last GAP cycle of the final burst).
   - Required: IDLE at 105, timed_out stays 0.
6. Retrigger.
   - Stimulus: alarm_trigger pulses at cycles 0, 15 and 40.
   - Required: cadence identical to scenario 2.
